csr_irq_unit: RTL

- Machine-mode-only Zicsr register file and trap controller for the 3-stage RV32I pipeline; sits in the execute stage.
- Next generation of the existing CSR block. It adds:
  - mie/mip with timer, software, external and NUM_LOCAL_IRQ local interrupts;
  - vectored mtvec mode;
  - 64-bit mcycle/minstret counters with read-only user shadows.
- The pipeline redirects fetch to trap_target whenever trap_taken or mret_taken is asserted.

---
 rtl/csr_irq_unit.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/csr_irq_unit.sv
// Machine-mode Zicsr register file and trap controller for the execute stage.
// Handles exceptions, prioritised interrupts, mret and the 64-bit counters.
module csr_irq_unit #(
  parameter int unsigned NUM_LOCAL_IRQ = 4,
  parameter bit          VECTORED_EN   = 1'b1,
  parameter bit          COUNTER_EN    = 1'b1,
  parameter logic [31:0] RESET_MTVEC   = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [11:0]              addr,
  input  logic [4:0]               uimm,
  input  logic [31:0]              rs1_data,
  input  logic [31:0]              pc,
  input  logic [2:0]               funct3,
  input  logic                     zicsr,
  input  logic                     illegal_inst,
  input  logic                     ecall,
  input  logic                     mret,
  input  logic                     instret,
  input  logic                     irq_take_en,
  input  logic                     timer_irq,
  input  logic                     sw_irq,
  input  logic                     ext_irq,
  input  logic [NUM_LOCAL_IRQ-1:0] local_irq,
  output logic [31:0]              r_data,
  output logic                     trap_taken,
  output logic                     mret_taken,
  output logic [31:0]              trap_target,
  output logic                     irq_pending
);

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  localparam logic [31:0] LOCAL_MASK = 32'(((64'd1 << NUM_LOCAL_IRQ) - 64'd1) << 16);
  localparam logic [31:0] MIE_MASK   = LOCAL_MASK | 32'h0000_0888;

  logic        st_mie, st_mpie;
  logic [31:0] mtvec_q, mepc_q, mcause_q, mscratch_q, mie_q, mip_q, mip_d;
  logic [63:0] mcycle_q, minstret_q;

  logic [31:0] csr_rdata, operand, wdata, pend, base;
  logic [NUM_LOCAL_IRQ-1:0] local_pend;
  logic [4:0]  irq_cause;
  logic        csr_ro, csr_wr_req, csr_ill, exc, do_mret, do_irq, csr_we;

  // Interrupt sources sampled into mip one cycle after they assert
  always_comb begin
    mip_d     = '0;
    mip_d[3]  = sw_irq;
    mip_d[7]  = timer_irq;
    mip_d[11] = ext_irq;
    for (int i = 0; i < int'(NUM_LOCAL_IRQ); i++) mip_d[16+i] = local_irq[i];
  end

  assign pend        = mip_q & mie_q;
  assign local_pend  = pend[16 +: NUM_LOCAL_IRQ];
  assign irq_pending = st_mie & (|pend);

  // Lowest-priority first so the later assignments win: MEI > MSI > MTI > local[0..]
  always_comb begin
    irq_cause = 5'd0;
    for (int i = int'(NUM_LOCAL_IRQ) - 1; i >= 0; i--)
      if (local_pend[i]) irq_cause = 5'(16 + i);
    if (pend[7])  irq_cause = 5'd7;
    if (pend[3])  irq_cause = 5'd3;
    if (pend[11]) irq_cause = 5'd11;
  end

  always_comb begin
    csr_rdata = 32'h0;
    case (addr)
      CSR_MSTATUS:               csr_rdata = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
      CSR_MISA:                  csr_rdata = 32'h4000_0100;
      CSR_MIE:                   csr_rdata = mie_q;
      CSR_MTVEC:                 csr_rdata = mtvec_q;
      CSR_MSCRATCH:              csr_rdata = mscratch_q;
      CSR_MEPC:                  csr_rdata = mepc_q;
      CSR_MCAUSE:                csr_rdata = mcause_q;
      CSR_MIP:                   csr_rdata = mip_q;
      CSR_MCYCLE,   CSR_CYCLE:   csr_rdata = mcycle_q[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:  csr_rdata = mcycle_q[63:32];
      CSR_MINSTRET, CSR_INSTRET: csr_rdata = minstret_q[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: csr_rdata = minstret_q[63:32];
      default:                   csr_rdata = 32'h0;
    endcase
  end

  assign r_data  = zicsr ? csr_rdata : 32'h0;
  assign operand = funct3[2] ? 32'(uimm) : rs1_data;

  always_comb begin
    case (funct3[1:0])
      2'b01:   wdata = operand;
      2'b10:   wdata = csr_rdata | operand;
      2'b11:   wdata = csr_rdata & ~operand;
      default: wdata = csr_rdata;
    endcase
  end

  // Set/clear with a zero operand is a pure read and must not disturb counters
  assign csr_ro     = (addr[11:10] == 2'b11);
  assign csr_wr_req = zicsr & ((funct3[1:0] == 2'b01) | (funct3[1] & (operand != 32'h0)));
  assign csr_ill    = zicsr & csr_ro & ~((funct3[1:0] == 2'b10) & (operand == 32'h0));
  assign exc        = illegal_inst | ecall | csr_ill;
  assign do_mret    = mret & ~exc;
  assign do_irq     = irq_pending & irq_take_en & ~exc & ~mret;
  assign csr_we     = csr_wr_req & ~csr_ro & ~exc & ~mret & ~do_irq;

  assign trap_taken = exc | do_irq;
  assign mret_taken = do_mret;
  assign base       = {mtvec_q[31:2], 2'b00};

  always_comb begin
    trap_target = base;
    if (do_mret)                  trap_target = mepc_q;
    else if (do_irq && mtvec_q[0]) trap_target = base + 32'({irq_cause, 2'b00});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mtvec_q    <= RESET_MTVEC;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      mscratch_q <= 32'h0;
      mie_q      <= 32'h0;
      mip_q      <= 32'h0;
    end else begin
      mip_q <= mip_d;
      if (exc) begin
        mepc_q   <= pc;
        mcause_q <= (!illegal_inst && ecall) ? 32'd11 : 32'd2;
        st_mpie  <= st_mie;
        st_mie   <= 1'b0;
      end else if (do_mret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end else if (do_irq) begin
        mepc_q   <= pc;
        mcause_q <= {1'b1, 26'b0, irq_cause};
        st_mpie  <= st_mie;
        st_mie   <= 1'b0;
      end else if (csr_we) begin
        case (addr)
          CSR_MSTATUS: begin
            st_mie  <= wdata[3];
            st_mpie <= wdata[7];
          end
          CSR_MIE:      mie_q      <= wdata & MIE_MASK;
          CSR_MTVEC:    mtvec_q    <= {wdata[31:2], 1'b0, wdata[0] & VECTORED_EN};
          CSR_MSCRATCH: mscratch_q <= wdata;
          CSR_MEPC:     mepc_q     <= wdata;
          CSR_MCAUSE:   mcause_q   <= wdata;
          default: ;
        endcase
      end
    end
  end

  // A write to either half replaces that cycle's increment of the whole counter
  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
    end else if (COUNTER_EN) begin
      if (csr_we && addr == CSR_MCYCLE)       mcycle_q <= {mcycle_q[63:32], wdata};
      else if (csr_we && addr == CSR_MCYCLEH) mcycle_q <= {wdata, mcycle_q[31:0]};
      else                                    mcycle_q <= mcycle_q + 64'd1;

      if (csr_we && addr == CSR_MINSTRET)       minstret_q <= {minstret_q[63:32], wdata};
      else if (csr_we && addr == CSR_MINSTRETH) minstret_q <= {wdata, minstret_q[31:0]};
      else if (instret)                         minstret_q <= minstret_q + 64'd1;
    end
  end

endmodule
